// File: rtl/game_pkg.sv
// Shared state encoding, widths and default timing for the game sequencer.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CRASH = 2'd2,
      ST_OVER  = 2'd3
   } game_state_e;

   localparam int SPEED_W            = 3;
   localparam int DEF_LIVES          = 3;
   localparam int DEF_CRASH_FRAMES   = 120;
   localparam int DEF_SPEEDUP_FRAMES = 600;

   function automatic int cnt_width(input int terminal);
      return (terminal > 1) ? $clog2(terminal) : 1;
   endfunction

endpackage

// File: rtl/frame_counter.sv
// Frame-rate counter: counts enabled cycles 0..TERMINAL-1, wraps, and pulses
// o_term in the cycle that wraps. Synchronous clear beats enable.
module frame_counter
   import game_pkg::*;
#(
   parameter int TERMINAL = 4,
   parameter int WIDTH    = cnt_width(TERMINAL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count,
   output logic             o_term
);

   logic [WIDTH-1:0] r_count;
   logic             w_at_last;

   assign w_at_last = (r_count == WIDTH'(TERMINAL - 1));
   assign o_term    = i_en & ~i_clr & w_at_last;
   assign o_count   = r_count;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_en)
         r_count <= w_at_last ? '0 : r_count + WIDTH'(1);
   end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE -> PLAY -> CRASH -> PLAY/OVER, with score, lives,
// speed level, car blink and a respawn pulse for the display datapath.
module game_ctrl
   import game_pkg::*;
#(
   parameter int SCORE_WIDTH    = 16,
   parameter int LIVES          = DEF_LIVES,
   parameter int CRASH_FRAMES   = DEF_CRASH_FRAMES,
   parameter int SPEEDUP_FRAMES = DEF_SPEEDUP_FRAMES,
   parameter int MAX_SPEED      = 7,
   parameter int BLINK_BIT      = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_end,
   input  logic                   start_btn,
   input  logic                   collide,
   output logic                   run,
   output logic [SPEED_W-1:0]     speed,
   output logic [SCORE_WIDTH-1:0] score,
   output logic [1:0]             lives,
   output logic [1:0]             state,
   output logic                   car_visible,
   output logic                   respawn
);

   localparam int                     SPD_CW     = cnt_width(SPEEDUP_FRAMES);
   localparam int                     CRS_CW     = cnt_width(CRASH_FRAMES);
   localparam logic [SPEED_W-1:0]     SPEED_MAX  = SPEED_W'(MAX_SPEED);
   localparam logic [SPEED_W-1:0]     SPEED_MIN  = SPEED_W'(1);
   localparam logic [1:0]             LIVES_INIT = 2'(LIVES);
   localparam logic [SCORE_WIDTH-1:0] SCORE_SAT  = '1;

   game_state_e            r_state, w_state_nxt;
   logic                   r_run, w_run_nxt;
   logic [SPEED_W-1:0]     r_speed, w_speed_nxt;
   logic [SCORE_WIDTH-1:0] r_score, w_score_nxt, w_score_add;
   logic [SCORE_WIDTH:0]   w_score_sum;
   logic [1:0]             r_lives, w_lives_nxt;
   logic                   r_car_visible, w_vis_nxt;
   logic                   r_respawn, w_resp_nxt;
   logic                   r_start_q, r_start_arm, w_start_rise;
   logic                   w_spd_en, w_spd_clr, w_spd_term;
   logic                   w_crs_en, w_crs_clr, w_crs_term;
   logic [SPD_CW-1:0]      w_spd_cnt;
   logic [CRS_CW-1:0]      w_crs_cnt;
   logic                   w_unused;

   // The arm flop keeps a button already held at reset release from reading as an edge.
   assign w_start_rise = start_btn & ~r_start_q & r_start_arm;
   assign w_spd_en     = frame_end & ~collide & (r_state == ST_PLAY);
   assign w_crs_en     = frame_end & (r_state == ST_CRASH);
   assign w_score_sum  = {1'b0, r_score} + (SCORE_WIDTH + 1)'(r_speed);
   assign w_score_add  = w_score_sum[SCORE_WIDTH] ? SCORE_SAT : w_score_sum[SCORE_WIDTH-1:0];
   assign w_unused     = ^{w_spd_cnt, w_crs_cnt};

   frame_counter #(.TERMINAL(SPEEDUP_FRAMES), .WIDTH(SPD_CW)) u_speedup_timer (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_spd_en),
      .i_clr  (w_spd_clr),
      .o_count(w_spd_cnt),
      .o_term (w_spd_term)
   );

   frame_counter #(.TERMINAL(CRASH_FRAMES), .WIDTH(CRS_CW)) u_crash_timer (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_crs_en),
      .i_clr  (w_crs_clr),
      .o_count(w_crs_cnt),
      .o_term (w_crs_term)
   );

   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_speed_nxt = r_speed;
      w_score_nxt = r_score;
      w_lives_nxt = r_lives;
      w_vis_nxt   = r_car_visible;
      w_resp_nxt  = 1'b0;
      w_spd_clr   = 1'b0;
      w_crs_clr   = 1'b0;
      case (r_state)
         ST_IDLE, ST_OVER: begin
            w_vis_nxt = 1'b1;
            if (w_start_rise) begin
               w_state_nxt = ST_PLAY;
               w_score_nxt = '0;
               w_lives_nxt = LIVES_INIT;
               w_speed_nxt = SPEED_MIN;
               w_spd_clr   = 1'b1;
               w_resp_nxt  = 1'b1;
            end
         end
         ST_PLAY: begin
            if (collide) begin
               w_state_nxt = ST_CRASH;
               w_lives_nxt = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
               w_crs_clr   = 1'b1;
               w_vis_nxt   = 1'b1;
            end else if (frame_end) begin
               w_score_nxt = w_score_add;
               if (w_spd_term && (r_speed < SPEED_MAX))
                  w_speed_nxt = r_speed + SPEED_W'(1);
            end
         end
         ST_CRASH: begin
            if (w_crs_term) begin
               w_vis_nxt = 1'b1;
               if (r_lives == 2'd0) begin
                  w_state_nxt = ST_OVER;
               end else begin
                  w_state_nxt = ST_PLAY;
                  w_speed_nxt = SPEED_MIN;
                  w_spd_clr   = 1'b1;
                  w_resp_nxt  = 1'b1;
               end
            end else if (frame_end) begin
               // Blink follows the crash count as it stood before this frame.
               w_vis_nxt = ~w_crs_cnt[BLINK_BIT];
            end
         end
      endcase
   end

   assign w_run_nxt = (w_state_nxt == ST_PLAY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_run         <= 1'b0;
         r_speed       <= SPEED_MIN;
         r_score       <= '0;
         r_lives       <= LIVES_INIT;
         r_car_visible <= 1'b1;
         r_respawn     <= 1'b0;
         r_start_q     <= 1'b0;
         r_start_arm   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_run         <= w_run_nxt;
         r_speed       <= w_speed_nxt;
         r_score       <= w_score_nxt;
         r_lives       <= w_lives_nxt;
         r_car_visible <= w_vis_nxt;
         r_respawn     <= w_resp_nxt;
         r_start_q     <= start_btn;
         r_start_arm   <= 1'b1;
      end
   end

   assign run         = r_run;
   assign speed       = r_speed;
   assign score       = r_score;
   assign lives       = r_lives;
   assign state       = r_state;
   assign car_visible = r_car_visible;
   assign respawn     = r_respawn;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed walk through a full game plus randomized play,
// all outputs compared every cycle against a frame-level game model.
module tb_game_ctrl;

   localparam int SW   = 6;
   localparam int LV   = 2;
   localparam int CF   = 4;
   localparam int SF   = 4;
   localparam int MS   = 3;
   localparam int BB   = 1;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_end, start_btn, collide;
   logic          run, car_visible, respawn;
   logic [2:0]    speed;
   logic [SW-1:0] score;
   logic [1:0]    lives, state;
   logic          prev_resp = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   game_ctrl #(
      .SCORE_WIDTH(SW), .LIVES(LV), .CRASH_FRAMES(CF),
      .SPEEDUP_FRAMES(SF), .MAX_SPEED(MS), .BLINK_BIT(BB)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .frame_end  (frame_end),
      .start_btn  (start_btn),
      .collide    (collide),
      .run        (run),
      .speed      (speed),
      .score      (score),
      .lives      (lives),
      .state      (state),
      .car_visible(car_visible),
      .respawn    (respawn)
   );

   always #5 clk = ~clk;

   // Game model: states 0 idle, 1 play, 2 crash, 3 over; counts in whole frames.
   typedef struct packed {
      int state;
      int score;
      int lives;
      int speed;
      int play_frames;
      int crash_frames;
      bit vis;
      bit resp;
      bit have_level;
      bit last_level;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r = '0;
      r.lives = LV;
      r.speed = 1;
      r.vis   = 1'b1;
      return r;
   endfunction

   function automatic model_t model_next(model_t c, logic sb, logic fe, logic co);
      model_t n;
      bit     rise;
      n = c;
      rise = c.have_level && sb && !c.last_level;
      n.have_level = 1'b1;
      n.last_level = sb;
      n.resp       = 1'b0;
      case (c.state)
         0, 3: begin
            if (rise) begin
               n.state = 1;  n.score = 0;  n.lives = LV;  n.speed = 1;
               n.play_frames = 0;  n.resp = 1'b1;  n.vis = 1'b1;
            end
         end
         1: begin
            if (co) begin
               n.state = 2;
               n.lives = (c.lives > 0) ? c.lives - 1 : 0;
               n.crash_frames = 0;
               n.vis = 1'b1;
            end else if (fe) begin
               n.score = (c.score + c.speed > SMAX) ? SMAX : c.score + c.speed;
               n.play_frames = c.play_frames + 1;
               if (n.play_frames == SF) begin
                  n.play_frames = 0;
                  n.speed = (c.speed < MS) ? c.speed + 1 : MS;
               end
            end
         end
         2: begin
            if (fe) begin
               n.crash_frames = c.crash_frames + 1;
               if (n.crash_frames == CF) begin
                  n.vis = 1'b1;
                  if (c.lives == 0) begin
                     n.state = 3;
                  end else begin
                     n.state = 1;  n.resp = 1'b1;  n.speed = 1;  n.play_frames = 0;
                  end
               end else begin
                  n.vis = ((c.crash_frames / (1 << BB)) % 2) == 0;
               end
            end
         end
         default: ;
      endcase
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= model_reset();
      else     m <= model_next(m, start_btn, frame_end, collide);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("m_state",   32'(state),       m.state);
      check("m_run",     32'(run),         32'(m.state == 1));
      check("m_speed",   32'(speed),       m.speed);
      check("m_score",   32'(score),       m.score);
      check("m_lives",   32'(lives),       m.lives);
      check("m_visible", 32'(car_visible), 32'(m.vis));
      check("m_respawn", 32'(respawn),     32'(m.resp));
      check("respawn_double", 32'(respawn & prev_resp), 0);
      prev_resp <= respawn;
   end

   task automatic cyc(input bit fe, input bit co);
      frame_end = fe;
      collide   = co;
      @(negedge clk);
      frame_end = 1'b0;
      collide   = 1'b0;
   endtask

   task automatic frame();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   task automatic start_press();
      start_btn = 1'b0;
      cyc(1'b0, 1'b0);
      start_btn = 1'b1;
      cyc(1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;  start_btn = 1'b1;  frame_end = 1'b0;  collide = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(i[0], 1'b0);
         check("held_start_state", 32'(state), 0);
         check("held_start_respawn", 32'(respawn), 0);
      end
      check("idle_run", 32'(run), 0);
      check("idle_lives", 32'(lives), 2);

      start_press();
      check("start_state", 32'(state), 1);
      check("start_respawn", 32'(respawn), 1);
      check("start_run", 32'(run), 1);
      cyc(1'b0, 1'b0);
      check("start_respawn_drop", 32'(respawn), 0);
      repeat (4) frame();
      check("play4_score", 32'(score), 4);
      check("play4_speed", 32'(speed), 2);

      cyc(1'b1, 1'b1);
      check("crash1_state", 32'(state), 2);
      check("crash1_lives", 32'(lives), 1);
      check("crash1_score", 32'(score), 4);
      check("crash1_run", 32'(run), 0);
      cyc(1'b0, 1'b0);
      frame();  check("blink_f1", 32'(car_visible), 1);
      frame();  check("blink_f2", 32'(car_visible), 1);
      frame();  check("blink_f3", 32'(car_visible), 0);
      cyc(1'b1, 1'b0);
      check("resume_state", 32'(state), 1);
      check("resume_respawn", 32'(respawn), 1);
      check("resume_speed", 32'(speed), 1);
      check("resume_score", 32'(score), 4);
      check("resume_visible", 32'(car_visible), 1);
      cyc(1'b0, 1'b0);

      repeat (12) frame();
      check("play12_speed", 32'(speed), 3);
      check("play12_score", 32'(score), 28);
      repeat (4) frame();
      check("speed_hold", 32'(speed), 3);
      check("play16_score", 32'(score), 40);
      repeat (8) frame();
      check("score_saturate", 32'(score), 63);

      cyc(1'b0, 1'b1);
      check("crash2_state", 32'(state), 2);
      check("crash2_lives", 32'(lives), 0);
      cyc(1'b0, 1'b0);
      repeat (4) frame();
      check("over_state", 32'(state), 3);
      check("over_run", 32'(run), 0);
      check("over_score", 32'(score), 63);
      repeat (3) cyc(1'b1, 1'b0);
      check("over_hold", 32'(state), 3);

      start_press();
      check("restart_state", 32'(state), 1);
      check("restart_lives", 32'(lives), 2);
      check("restart_score", 32'(score), 0);
      check("restart_respawn", 32'(respawn), 1);
      cyc(1'b0, 1'b0);
      frame();
      check("restart_score1", 32'(score), 1);
      cyc(1'b0, 1'b1);
      check("crash3_state", 32'(state), 2);
      frame();

      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_state", 32'(state), 0);
      check("async_run", 32'(run), 0);
      check("async_speed", 32'(speed), 1);
      check("async_score", 32'(score), 0);
      check("async_lives", 32'(lives), 2);
      check("async_visible", 32'(car_visible), 1);
      check("async_respawn", 32'(respawn), 0);
      @(negedge clk);
      rst = 1'b0;

      start_btn = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         frame_end = ($urandom_range(0, 3) == 0);
         collide   = ($urandom_range(0, 119) == 0);
         if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
         rst = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      rst = 1'b0;  frame_end = 1'b0;  collide = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
